// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexes four BCD digits onto a 4-digit common-anode
// 7-segment display with frame-consistent snapshots, leading-zero blanking
// and a fixed decimal-point position. All outputs are registered and active-low.
module seven_seg_scan #(
    parameter int unsigned REFRESH_CYCLES = 4,
    parameter int unsigned DP_POS         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       blank_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [1:0] DP_SEL = 2'(DP_POS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       s3_q, s2_q, s1_q, s0_q;
    logic [3:0]       s3_d, s2_d, s1_d, s0_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             wrap;
    logic             snap_load;
    logic             blank3, blank2, blank_sel;
    logic [3:0]       digit;

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next-state: refresh counter, digit select, snapshot and output image
    always_comb begin
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        s3_d      = s3_q;
        s2_d      = s2_q;
        s1_d      = s1_q;
        s0_d      = s0_q;
        digit     = s0_q;
        blank_sel = 1'b0;
        an_d      = 4'b1111;
        seg_d     = 7'b1111111;
        dp_d      = 1'b1;

        wrap      = (cnt_q == CNT_LAST);
        snap_load = wrap && (sel_q == 2'd3);

        if (wrap) begin
            cnt_d = '0;
            sel_d = sel_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Snapshot only at the frame wrap so a whole frame shows one value
        if (snap_load) begin
            s3_d = d3;
            s2_d = d2;
            s1_d = d1;
            s0_d = d0;
        end

        blank3 = blank_en && (s3_q == 4'd0);
        blank2 = blank3 && (s2_q == 4'd0);

        case (sel_q)
            2'd0: digit = s0_q;
            2'd1: digit = s1_q;
            2'd2: begin
                digit     = s2_q;
                blank_sel = blank2;
            end
            default: begin
                digit     = s3_q;
                blank_sel = blank3;
            end
        endcase

        if (!blank_sel) begin
            an_d  = ~(4'b0001 << sel_q);
            seg_d = decode(digit);
            dp_d  = (sel_q != DP_SEL);
        end
    end

    // State and output registers; synchronous reset also samples the inputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            sel_q <= 2'd0;
            s3_q  <= d3;
            s2_q  <= d2;
            s1_q  <= d1;
            s0_q  <= d0;
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            s3_q  <= s3_d;
            s2_q  <= s2_d;
            s1_q  <= s1_d;
            s0_q  <= s0_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_CYCLES=4, DP_POS=1.
module tb_seven_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d3, d2, d1, d0;
    logic       blank_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] AN0 = 4'b1110;
    localparam logic [3:0] AN1 = 4'b1101;
    localparam logic [3:0] AN2 = 4'b1011;
    localparam logic [3:0] AN3 = 4'b0111;
    localparam logic [3:0] ANX = 4'b1111;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SX = 7'b1111111;

    seven_seg_scan #(
        .REFRESH_CYCLES(4),
        .DP_POS        (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0),
        .blank_en(blank_en),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        assert ({an, seg, dp} === {ea, es, ed})
        else begin
            errors++;
            $error("FAIL %s: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   tag, an, seg, dp, ea, es, ed);
        end
    endtask

    // One digit slot: four consecutive edges with identical outputs
    task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        for (int i = 0; i < 4; i++) begin
            step();
            chk(tag, ea, es, ed);
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d);
        d3 = a; d2 = b; d1 = c; d0 = d;
    endtask

    initial begin
        rst = 1'b0;
        blank_en = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        // 1. reset held for 3 cycles, then release
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", ANX, SX, 1'b1);
        end
        rst = 1'b1;
        step();
        chk("reset_exit", AN0, S0, 1'b1);

        // 2. scan order with 1,2,3,4 loaded during reset
        rst = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        step();
        chk("reset2", ANX, SX, 1'b1);
        rst = 1'b1;
        slot("scan_f1_d0", AN0, S4, 1'b1);
        slot("scan_f1_d1", AN1, S3, 1'b0);
        slot("scan_f1_d2", AN2, S2, 1'b1);
        slot("scan_f1_d3", AN3, S1, 1'b1);
        slot("scan_f2_d0", AN0, S4, 1'b1);

        // 3. mid-frame input change (sel==1) held until next frame
        d0 = 4'd7;
        d2 = 4'd9;
        slot("snap_f2_d1", AN1, S3, 1'b0);
        slot("snap_f2_d2", AN2, S2, 1'b1);
        slot("snap_f2_d3", AN3, S1, 1'b1);
        slot("snap_f3_d0", AN0, S7, 1'b1);
        slot("snap_f3_d1", AN1, S3, 1'b0);
        slot("snap_f3_d2", AN2, S9, 1'b1);
        slot("snap_f3_d3", AN3, S1, 1'b1);

        // 4. leading-zero blanking on 0,0,5,9 then disabled
        rst = 1'b0;
        set_digits(4'd0, 4'd0, 4'd5, 4'd9);
        blank_en = 1'b1;
        step();
        chk("reset3", ANX, SX, 1'b1);
        rst = 1'b1;
        slot("blank_d0", AN0, S9, 1'b1);
        slot("blank_d1", AN1, S5, 1'b0);
        slot("blank_d2", ANX, SX, 1'b1);
        slot("blank_d3", ANX, SX, 1'b1);
        blank_en = 1'b0;
        slot("noblank_d0", AN0, S9, 1'b1);
        slot("noblank_d1", AN1, S5, 1'b0);
        slot("noblank_d2", AN2, S0, 1'b1);
        slot("noblank_d3", AN3, S0, 1'b1);

        // 5. non-BCD dashes and partial blanking (only digit 3 blanked)
        rst = 1'b0;
        set_digits(4'd0, 4'hC, 4'hF, 4'd1);
        blank_en = 1'b1;
        step();
        chk("reset4", ANX, SX, 1'b1);
        rst = 1'b1;
        slot("bcd_d0", AN0, S1, 1'b1);
        slot("bcd_d1", AN1, SD, 1'b0);
        slot("bcd_d2", AN2, SD, 1'b1);
        slot("bcd_d3", ANX, SX, 1'b1);

        // 6. reset asserted while sel==2, snapshot takes inputs sampled in reset
        set_digits(4'd8, 4'd7, 4'd6, 4'd5);
        slot("pre_rst_d0", AN0, S1, 1'b1);
        slot("pre_rst_d1", AN1, SD, 1'b0);
        rst = 1'b0;
        step();
        chk("midscan_reset", ANX, SX, 1'b1);
        rst = 1'b1;
        slot("restart_d0", AN0, S5, 1'b1);
        slot("restart_d1", AN1, S6, 1'b0);
        slot("restart_d2", AN2, S7, 1'b1);
        slot("restart_d3", AN3, S8, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
